// File: rtl/bp_bht_btb_pkg.sv
// Shared constants and helpers for the PHT/BTB branch predictor.
package bp_bht_btb_pkg;

    // Word-aligned PCs: index bits start just above the byte offset.
    localparam int PC_IDX_LSB = 2;

    // Reset value of a PHT counter: weakly not-taken.
    function automatic int cnt_init(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    // Saturation ceiling of a PHT counter.
    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    // Table index width for a given depth.
    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // Lowest PC bit of the BTB tag.
    function automatic int tag_lsb(input int entries);
        return $clog2(entries) + PC_IDX_LSB;
    endfunction

    // PHT index hash shared by lookup and update: bimodal or gshare.
    function automatic logic [31:0] pht_hash(input logic [31:0] b_idx,
                                             input logic [31:0] ghr,
                                             input bit          gshare);
        return gshare ? (b_idx ^ ghr) : b_idx;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter used for one PHT entry.
module bp_sat_counter
    import bp_bht_btb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Step toward taken or not-taken, clamping at both ends.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (inc && !dec && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (dec && !inc && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Counter register, returns to weakly not-taken on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/bp_bht_btb.sv
// Branch predictor: PC/gshare-indexed PHT plus tagged BTB, combinational lookup.
module bp_bht_btb
    import bp_bht_btb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 8,
    parameter int GHR_W   = 4,
    parameter int GSHARE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      f_pc,
    input  logic             f_fire,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [GHR_W-1:0] f_ghr,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_is_branch,
    input  logic             upd_is_jump,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_mispredict,
    input  logic             bp_clr
);

    localparam int IDX_W   = idx_w(ENTRIES);
    localparam int TAG_LSB = tag_lsb(ENTRIES);
    localparam bit USE_GS  = (GSHARE != 0);

    logic [IDX_W-1:0] f_bidx, f_pidx, u_bidx, u_pidx;
    logic [TAG_W-1:0] f_tag, u_tag;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] jump_q, jump_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [GHR_W-1:0]   ghr_q, ghr_d;

    logic [CNT_W-1:0]   pht_cnt [ENTRIES];
    logic [ENTRIES-1:0] pht_en;
    logic               btb_we;
    logic               unused_pc_bits;

    // Shift one outcome into a history value; also covers GHR_W == 1.
    function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] h,
                                                   input logic             b);
        return (h << 1) | GHR_W'(b);
    endfunction

    assign f_bidx = f_pc[IDX_W+PC_IDX_LSB-1:PC_IDX_LSB];
    assign u_bidx = upd_pc[IDX_W+PC_IDX_LSB-1:PC_IDX_LSB];
    assign f_tag  = f_pc[TAG_LSB+TAG_W-1:TAG_LSB];
    assign u_tag  = upd_pc[TAG_LSB+TAG_W-1:TAG_LSB];
    // Update indexes with the instruction's own history snapshot, not the live GHR.
    assign f_pidx = IDX_W'(pht_hash(32'(f_bidx), 32'(ghr_q), USE_GS));
    assign u_pidx = IDX_W'(pht_hash(32'(u_bidx), 32'(upd_ghr), USE_GS));

    assign unused_pc_bits = ^{f_pc[31:TAG_LSB+TAG_W], f_pc[PC_IDX_LSB-1:0],
                              upd_pc[31:TAG_LSB+TAG_W], upd_pc[PC_IDX_LSB-1:0]};

    // Lookup on registered state only; an update in the same cycle is not bypassed.
    always_comb begin
        pred_hit    = valid_q[f_bidx] && (tag_q[f_bidx] == f_tag);
        pred_taken  = pred_hit && (jump_q[f_bidx] || pht_cnt[f_pidx][CNT_W-1]);
        pred_target = pred_hit ? target_q[f_bidx] : 32'd0;
        f_ghr       = ghr_q;
    end

    // Only conditional branches train the PHT.
    always_comb begin
        pht_en = '0;
        if (upd_valid && upd_is_branch) begin
            pht_en[u_pidx] = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_pht
            bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk (clk),
                .rst (rst),
                .en  (pht_en[gi]),
                .inc (upd_taken),
                .dec (!upd_taken),
                .cnt (pht_cnt[gi])
            );
        end
    endgenerate

    // BTB allocate on taken branches and jumps; a clear overrides any write.
    always_comb begin
        valid_d  = valid_q;
        jump_d   = jump_q;
        tag_d    = tag_q;
        target_d = target_q;
        btb_we   = upd_valid && ((upd_is_branch && upd_taken) || upd_is_jump);
        if (btb_we) begin
            valid_d[u_bidx]  = 1'b1;
            jump_d[u_bidx]   = upd_is_jump;
            tag_d[u_bidx]    = u_tag;
            target_d[u_bidx] = upd_target;
        end
        if (bp_clr) begin
            valid_d = '0;
        end
    end

    // GHR: repair from resolution beats speculative shift at fetch.
    always_comb begin
        ghr_d = ghr_q;
        if (USE_GS) begin
            if (upd_valid && upd_mispredict && upd_is_branch) begin
                ghr_d = ghr_shift(upd_ghr, upd_taken);
            end else if (upd_valid && upd_mispredict && upd_is_jump) begin
                ghr_d = upd_ghr;
            end else if (f_fire && pred_hit && !jump_q[f_bidx]) begin
                ghr_d = ghr_shift(ghr_q, pred_taken);
            end
        end else begin
            ghr_d = '0;
        end
    end

    // Predictor state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            jump_q  <= '0;
            ghr_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            jump_q   <= jump_d;
            ghr_q    <= ghr_d;
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

endmodule

// File: doc/bp_bht_btb.md
Name: bp_bht_btb

Overview:
- Parametrised successor to the single-counter branch predictor in the 5-stage RISC-V pipeline.
- Contains a PC-indexed pattern history table (PHT) of saturating counters and a tagged branch target buffer (BTB).
- The optional gshare mode adds a global history register (GHR).
- Lookup is combinational in IF, so the next-PC logic gets direction and target without decoding. Update comes from E/M resolution: branch_taken, is_branch, jump type, jb_addr.

Parameters:
- ENTRIES, 16: PHT and BTB depth, power of two ≥ 2; IDX_W = clog2(ENTRIES).
- CNT_W, 2: PHT counter width, ≥ 1.
- TAG_W, 8: BTB tag width; tag = pc[IDX_W+2+TAG_W-1 : IDX_W+2].
- GHR_W, 4: global history length, 1..IDX_W.
- GSHARE, 0: 0 = bimodal PHT index, 1 = gshare PHT index.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- f_pc  in  32  IF-stage PC
- f_fire  in  1  IF advances this cycle (not PC-stalled)
- pred_hit  out  1  BTB valid and tag match for f_pc
- pred_taken  out  1  predicted taken
- pred_target  out  32  BTB target; 0 when pred_hit=0
- f_ghr  out  GHR_W  GHR snapshot, carried down the pipe with the instruction
- upd_valid  in  1  resolved control-flow instruction in E/M
- upd_pc  in  32  its PC
- upd_is_branch  in  1  conditional branch
- upd_is_jump  in  1  jal/jalr
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual target (jb_addr)
- upd_ghr  in  GHR_W  f_ghr snapshot of that instruction
- upd_mispredict  in  1  direction or target mispredicted (the pipeline flushes)
- bp_clr  in  1  synchronous invalidate of all BTB entries

Behaviour:
- Reset (async) and state:
  - All PHT counters = 2^(CNT_W-1)-1 (weakly not-taken).
  - All BTB valid = 0; tags, targets and jump flags = 0.
  - GHR = 0.
  - Outputs therefore read pred_hit=0, pred_taken=0, pred_target=0, f_ghr=0.
- Indexing:
  - b_idx = pc[IDX_W+1:2].
  - p_idx = b_idx when GSHARE=0; b_idx XOR zero-extended GHR when GSHARE=1.
  - On update, p_idx uses upd_ghr, not the live GHR.
- Lookup (zero latency, combinational on registered state):
  - pred_hit = valid[b_idx] & (tag[b_idx]==tag(f_pc)).
  - pred_taken = pred_hit & (jump[b_idx] | PHT[p_idx][CNT_W-1]).
  - pred_target = pred_hit ? target[b_idx] : 0.
- Update (one cycle; takes effect at the clk edge when upd_valid=1):
  - upd_is_branch: PHT[p_idx] is incremented when upd_taken=1, saturating at 2^CNT_W-1. It is decremented when upd_taken=0, saturating at 0.
  - upd_is_jump: PHT is untouched.
  - BTB write when (upd_is_branch & upd_taken) | upd_is_jump: valid=1, tag, target=upd_target, jump=upd_is_jump. An existing entry with a different tag is overwritten.
  - Not-taken branch: the BTB is untouched.
  - upd_valid with neither upd_is_branch nor upd_is_jump: no state change.
- GHR (GSHARE=1 only; in bimodal mode the register is held at 0):
  - Priority 1: upd_valid & upd_mispredict & upd_is_branch gives GHR <= {upd_ghr[GHR_W-2:0], upd_taken}. This is the repair.
  - Priority 2: upd_valid & upd_mispredict & upd_is_jump gives GHR <= upd_ghr. This restores the history; jumps are not shifted in.
  - Priority 3: f_fire & pred_hit & !jump[b_idx] gives a speculative shift: GHR <= {GHR[GHR_W-2:0], pred_taken}.
  - Otherwise the GHR holds.
  - When a repair and f_fire occur in the same cycle, the repair wins; the fetched instruction is flushed anyway.
  - For GHR_W=1, shift means GHR <= new bit.
- Simultaneous events:
  - Lookup and update to the same index in the same cycle: the lookup returns the pre-update value. There is no bypass.
  - bp_clr and a BTB write in the same cycle: bp_clr wins, all valid=0. The PHT and GHR are unaffected by bp_clr.
- Reset asserted mid-operation returns all state immediately to reset values, with no dependence on clk.

Decomposition:
- Shared package/define file holds:
  - counter reset constant CNT_INIT and saturation limit CNT_MAX;
  - localparams IDX_W and tag slice offsets;
  - an index-hash function used by both lookup and update.
- One sub-module is natural: bp_sat_counter (CNT_W parameter; inc/dec/en inputs; saturating), instantiated per PHT entry via generate.
- The BTB arrays and GHR logic stay in bp_bht_btb.

Test Plan:
- Reset: assert rst mid-cycle with a trained table → outputs 0 immediately. After release, every f_pc gives pred_hit=0, pred_taken=0, and PHT reads 1 (CNT_W=2).
- Loop training (bimodal): update pc=0x40 taken, target 0x20, twice → lookup 0x40 gives pred_hit=1, pred_taken=1, pred_target=0x20. Then two not-taken updates → pred_taken=0, pred_hit=1.
- Saturation: five taken updates on pc=0x40 → counter 3. One not-taken → 2, still taken. A second → 1, not-taken.
- Alias/tag: train 0x40 taken, then update jal at 0x40+ENTRIES*4 (same index, new tag), target 0x100 → lookup 0x40 gives pred_hit=0; new pc gives pred_taken=1, target 0x100.
- Gshare (GSHARE=1): alternating T/N branch at 0x80 with correct upd_ghr → after a 16-iteration warmup, prediction matches outcome 100%. Bimodal reaches ≤50% on the same stimulus.
- Repair priority: GHR=0b1010 with f_fire & pred_hit, and upd_mispredict with upd_ghr=0b0011, upd_taken=1 in the same cycle → GHR=0b0111. Separately, bp_clr with a simultaneous BTB write → all pred_hit=0.
